// File: rtl/priority_arbiter_rr.sv
// Registered N-way request encoder with fixed-priority or round-robin selection.
// Each result is held on a valid/ready handshake until the consumer accepts it.
module priority_arbiter_rr #(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             rr_mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_grant,
    output logic             any_req,
    output logic             dbg_state,
    output logic [IDX_W-1:0] dbg_ptr
);

    // Handshake: a result transfers on any rising edge where out_valid && out_ready;
    // out_valid never drops and out_idx/out_grant never change until that transfer.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic             accept;
    logic [IDX_W-1:0] search_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_grant;
    logic             win_found;
    int               pos;

    // Wrap at N-1 so non-power-of-two N never points past the last request.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (int'(v) == N - 1) ? '0 : v + 1'b1;
    endfunction

    assign any_req   = |req;
    assign accept    = (state == HOLD) && out_ready;
    assign dbg_state = state;
    assign dbg_ptr   = ptr;

    // On an accepting edge the next winner must see the pointer as it will be after the edge.
    assign search_ptr = (accept && rr_mode) ? wrap_inc(out_idx) : ptr;

    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        pos       = 0;
        for (int i = 0; i < N; i++) begin
            pos = rr_mode ? int'(search_ptr) + i : i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!win_found && req[pos]) begin
                win_idx   = IDX_W'(pos);
                win_found = 1'b1;
            end
        end
    end

    assign win_grant = N'(1) << win_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_grant <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        out_valid <= 1'b1;
                        out_idx   <= win_idx;
                        out_grant <= win_grant;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (rr_mode) begin
                            ptr <= wrap_inc(out_idx);
                        end
                        if (any_req) begin
                            out_idx   <= win_idx;
                            out_grant <= win_grant;
                        end else begin
                            out_valid <= 1'b0;
                            out_grant <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    grant_matches_idx: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (out_grant == (N'(1) << out_idx)));
    idle_grant_clear: assert property (@(posedge clk) disable iff (!rst_n)
        !out_valid |-> (out_grant == '0));

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed bench for priority_arbiter_rr: N=4 vector table plus N=5 wrap and async-reset sequences.
module tb_priority_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [4:0] req5;
    logic       rr_mode;
    logic       out_ready;

    logic       out_valid;
    logic [1:0] out_idx;
    logic [3:0] out_grant;
    logic       any_req;
    logic       dbg_state;
    logic [1:0] dbg_ptr;

    logic       out_valid5;
    logic [2:0] out_idx5;
    logic [4:0] out_grant5;
    logic       any_req5;
    logic       dbg_state5;
    logic [2:0] dbg_ptr5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priority_arbiter_rr #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_mode(rr_mode), .out_ready(out_ready),
        .out_valid(out_valid), .out_idx(out_idx), .out_grant(out_grant), .any_req(any_req),
        .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    priority_arbiter_rr #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .rr_mode(rr_mode), .out_ready(out_ready),
        .out_valid(out_valid5), .out_idx(out_idx5), .out_grant(out_grant5), .any_req(any_req5),
        .dbg_state(dbg_state5), .dbg_ptr(dbg_ptr5)
    );

    typedef struct {
        logic [3:0] req;
        logic       mode;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_idx;
        logic [3:0] exp_grant;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual %0h required %0h", name, n, act, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req5      = '0;
        rr_mode   = 1'b0;
        out_ready = 1'b0;

        // Each record: inputs applied before an edge, outputs expected just after it.
        // Fixed priority.
        vecs.push_back('{4'b1110, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd0});
        vecs.push_back('{4'b1110, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd0});
        vecs.push_back('{4'b1110, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd0});
        vecs.push_back('{4'b1000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd0});
        vecs.push_back('{4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 2'd0});
        // Round-robin fairness with all requests held.
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0});
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 2'd2});
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd3});
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0});
        vecs.push_back('{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd1});
        // Backpressure: held result is sticky while req changes.
        vecs.push_back('{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd1});
        vecs.push_back('{4'b0001, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd1});
        vecs.push_back('{4'b0001, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd1});
        vecs.push_back('{4'b0001, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd1});
        vecs.push_back('{4'b0001, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd1});
        vecs.push_back('{4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd3});
        vecs.push_back('{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd1});
        // Mode switch: ptr survives a fixed-mode excursion.
        vecs.push_back('{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd1});
        vecs.push_back('{4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 2'd3});
        vecs.push_back('{4'b1001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd3});
        vecs.push_back('{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd3});
        vecs.push_back('{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd3});
        vecs.push_back('{4'b1001, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3});
        // Walk to HOLD with out_idx=2 and a nonzero ptr ahead of the async reset.
        vecs.push_back('{4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd0});
        vecs.push_back('{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 2'd2});
        vecs.push_back('{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd2});

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_valid", 0, 64'(out_valid), 64'd0);
        check("rst_idx",   0, 64'(out_idx),   64'd0);
        check("rst_grant", 0, 64'(out_grant), 64'd0);
        check("rst_ptr",   0, 64'(dbg_ptr),   64'd0);
        check("rst_state", 0, 64'(dbg_state), 64'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            req       = vecs[i].req;
            rr_mode   = vecs[i].mode;
            out_ready = vecs[i].ready;
            #1;
            check("any_req", i, 64'(any_req), 64'(|vecs[i].req));
            @(posedge clk);
            #1;
            check("valid", i, 64'(out_valid), 64'(vecs[i].exp_valid));
            check("state", i, 64'(dbg_state), 64'(vecs[i].exp_valid));
            check("idx",   i, 64'(out_idx),   64'(vecs[i].exp_idx));
            check("grant", i, 64'(out_grant), 64'(vecs[i].exp_grant));
            check("ptr",   i, 64'(dbg_ptr),   64'(vecs[i].exp_ptr));
        end

        // Async reset mid-HOLD takes effect with no clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 0, 64'(out_valid), 64'd0);
        check("arst_grant", 0, 64'(out_grant), 64'd0);
        check("arst_ptr",   0, 64'(dbg_ptr),   64'd0);
        check("arst_state", 0, 64'(dbg_state), 64'd0);
        @(negedge clk);
        req       = '0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("idle_valid", k, 64'(out_valid), 64'd0);
            check("idle_grant", k, 64'(out_grant), 64'd0);
        end

        // N=5 round-robin wrap at index 4.
        begin
            logic [2:0] exp_idx5[4];
            logic [2:0] exp_ptr5[4];
            exp_idx5 = '{3'd0, 3'd4, 3'd0, 3'd4};
            exp_ptr5 = '{3'd0, 3'd1, 3'd0, 3'd1};
            @(negedge clk);
            req5      = 5'b10001;
            rr_mode   = 1'b1;
            out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                check("n5_valid", k, 64'(out_valid5), 64'd1);
                check("n5_idx",   k, 64'(out_idx5),   64'(exp_idx5[k]));
                check("n5_grant", k, 64'(out_grant5), 64'(5'd1 << exp_idx5[k]));
                check("n5_ptr",   k, 64'(dbg_ptr5),   64'(exp_ptr5[k]));
            end
            @(negedge clk);
            req5 = '0;
            @(posedge clk);
            #1;
            check("n5_drain_valid", 0, 64'(out_valid5), 64'd0);
            check("n5_drain_ptr",   0, 64'(dbg_ptr5),   64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
